// File: rtl/pa_fdsu_pkg.sv
// ---------------------------------------------------------------------------
// pa_fdsu_pkg
// Shared definitions for the FDSU (floating-point divide / square-root)
// iteration control slice.
//   fdsu_state_e   : control FSM state encoding (IDLE, PREP, ITER, RND, WB)
//   FDSU_ITER_NUM  : number of SRT iterations for a full-length operation
//   FDSU_CNT_W     : width of the SRT iteration counter
//   FDSU_CNT_INIT  : counter value loaded on entry to ITER (counts down to 0)
// ---------------------------------------------------------------------------
package pa_fdsu_pkg;

    localparam int FDSU_ITER_NUM = 13;
    localparam int FDSU_CNT_W    = 4;

    // The counter runs FDSU_ITER_NUM-1 down to 0 inclusive, i.e. one ITER
    // cycle per iteration.
    localparam logic [FDSU_CNT_W-1:0] FDSU_CNT_INIT = FDSU_CNT_W'(FDSU_ITER_NUM - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        RND  = 3'd3,
        WB   = 3'd4
    } fdsu_state_e;

endpackage : pa_fdsu_pkg

// File: rtl/pa_fdsu_iter_cnt.sv
// ---------------------------------------------------------------------------
// pa_fdsu_iter_cnt
// Down-counter tracking the remaining SRT iterations.
// Ports:
//   clk       in   clock, all state on rising edge
//   srst      in   synchronous active-high reset (counter -> 0)
//   load      in   load FDSU_CNT_INIT (takes priority over dec)
//   dec       in   decrement by one (saturates at zero)
//   cnt       out  current count
//   cnt_zero  out  count equals zero
// ---------------------------------------------------------------------------
module pa_fdsu_iter_cnt
    import pa_fdsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load,
    input  logic                  dec,
    output logic [FDSU_CNT_W-1:0] cnt,
    output logic                  cnt_zero
);

    logic [FDSU_CNT_W-1:0] cnt_reg;
    logic [FDSU_CNT_W-1:0] cnt_next;

    assign cnt_zero = (cnt_reg == '0);
    assign cnt      = cnt_reg;

    // The last ITER cycle sees the count at zero; saturating there keeps the
    // held value meaningful (0) once the FSM has moved on to RND.
    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = FDSU_CNT_INIT;
        end else if (dec && !cnt_zero) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule : pa_fdsu_iter_cnt

// File: rtl/pa_fdsu_iter_ctrl.sv
// ---------------------------------------------------------------------------
// pa_fdsu_iter_ctrl
// Control FSM sequencing one FP divide / square-root operation through
// PREP (denormal normalisation), ITER (SRT iterations), RND (rounding) and
// WB (writeback handshake).
//
// Optional feature: define FDSU_EARLY_TERM_EN to let a zero partial
// remainder (srt_rem_zero) end the iteration phase early. When undefined,
// srt_rem_zero is ignored and every op runs the full 13 iterations.
//
// Ports:
//   forever_cpuclk   in   clock, all state on rising edge
//   cpurst           in   synchronous active-high reset
//   ex1_start        in   new op valid in EX1
//   ex1_div/ex1_sqrt in   op type (both set behaves as divide)
//   ex1_special      in   result already known, skip straight to WB
//   ex1_op0_id       in   operand 0 denormal, needs PREP cycle
//   ex1_op1_id_vld   in   operand 1 denormal, needs PREP cycle
//   srt_rem_zero     in   partial remainder zero (early termination)
//   wb_ack           in   writeback accepted (only honoured in WB)
//   flush            in   kill in-flight op, return to IDLE
//   ex1_ready        out  idle, can accept a new op
//   fdsu_busy        out  op in flight
//   ex1_pipedown     out  op accepted this cycle
//   srt_first_round  out  first ITER cycle
//   srt_iter_vld     out  in ITER
//   srt_cnt[3:0]     out  remaining iteration count
//   rnd_vld          out  in RND
//   wb_vld           out  in WB, result valid
//   wb_special       out  current result came from the special path
// ---------------------------------------------------------------------------
module pa_fdsu_iter_ctrl
    import pa_fdsu_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  ex1_start,
    input  logic                  ex1_div,
    input  logic                  ex1_sqrt,
    input  logic                  ex1_special,
    input  logic                  ex1_op0_id,
    input  logic                  ex1_op1_id_vld,
    input  logic                  srt_rem_zero,
    input  logic                  wb_ack,
    input  logic                  flush,
    output logic                  ex1_ready,
    output logic                  fdsu_busy,
    output logic                  ex1_pipedown,
    output logic                  srt_first_round,
    output logic                  srt_iter_vld,
    output logic [FDSU_CNT_W-1:0] srt_cnt,
    output logic                  rnd_vld,
    output logic                  wb_vld,
    output logic                  wb_special
);

    fdsu_state_e state_reg;
    fdsu_state_e state_next;

    logic        op_accept;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        early_exit;
    logic        wb_special_reg;

    // Only a recognised op type is taken; flush in the same cycle wins.
    assign op_accept = (state_reg == IDLE) && ex1_start
                       && (ex1_div || ex1_sqrt) && !flush;

    assign srt_iter_vld    = (state_reg == ITER);
    assign srt_first_round = srt_iter_vld && (srt_cnt == FDSU_CNT_INIT);

`ifdef FDSU_EARLY_TERM_EN
    // The first round's remainder reflects the unshifted operand, so a zero
    // there is not a valid termination signal.
    assign early_exit = srt_rem_zero && !srt_first_round;
`else
    logic unused_rem_zero;
    assign unused_rem_zero = srt_rem_zero;
    assign early_exit      = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (op_accept) begin
                    if (ex1_special) begin
                        state_next = WB;
                    end else if (ex1_op0_id || ex1_op1_id_vld) begin
                        state_next = PREP;
                    end else begin
                        state_next = ITER;
                    end
                end
            end
            PREP: state_next = ITER;
            ITER: begin
                if (cnt_zero || early_exit) begin
                    state_next = RND;
                end
            end
            RND:  state_next = WB;
            WB: begin
                if (wb_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush dominates every other transition.
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The result-kind flag is captured at accept and held for the whole op
    // so downstream logic can read it alongside wb_vld.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            wb_special_reg <= 1'b0;
        end else if (op_accept) begin
            wb_special_reg <= ex1_special;
        end
    end

    // Load on the transition into ITER (from IDLE or PREP), count while in it.
    assign cnt_load = (state_next == ITER) && (state_reg != ITER);
    assign cnt_dec  = (state_reg == ITER);

    pa_fdsu_iter_cnt u_iter_cnt (
        .clk      (forever_cpuclk),
        .srst     (cpurst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .cnt      (srt_cnt),
        .cnt_zero (cnt_zero)
    );

    assign ex1_ready    = (state_reg == IDLE);
    assign fdsu_busy    = !ex1_ready;
    assign ex1_pipedown = op_accept;
    assign rnd_vld      = (state_reg == RND);
    assign wb_vld       = (state_reg == WB);
    assign wb_special   = wb_special_reg;

endmodule : pa_fdsu_iter_ctrl
